adder_seq_ctrl: RTL and testbench

//  Controller plus datapath front end for the RTL adder. Accepts operands A then B over a

---
 rtl/adder_seq_ctrl_pkg.sv | 14 +
 rtl/adder_seq_ctrl_add_w.sv | 16 +
 rtl/adder_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_adder_seq_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_ctrl_pkg.sv
// Shared types and constants for the sequential adder controller.
// The result width is fixed to the 8-bit downstream reg8.
package adder_pkg;

  localparam int ADDER_WIDTH = 8;

  typedef enum logic [1:0] {
    S_WAIT_A,
    S_WAIT_B,
    S_ADD,
    S_DONE
  } adder_state_t;

endpackage

// File: rtl/adder_seq_ctrl_add_w.sv
// Combinational unsigned adder producing {cout, sum}.
// It is kept separate so the controller only handles sequencing.
module add_w
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Operand-collecting controller: takes A then B from a byte stream, adds them,
// strobes the result into the downstream reg8 and waits for acknowledgement.
module adder_seq_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] r_data,
  output logic             r_en,
  output logic             carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] op_count
);

  adder_state_t     state_reg, state_next;
  logic [WIDTH-1:0] opa_reg, opa_next;
  logic [WIDTH-1:0] opb_reg, opb_next;
  logic [WIDTH-1:0] r_data_reg, r_data_next;
  logic             carry_reg, carry_next;
  logic             r_en_reg, r_en_next;
  logic             out_valid_reg, out_valid_next;
  logic [CNT_W-1:0] op_count_reg, op_count_next;

  logic [WIDTH-1:0] sum;
  logic             cout;

  add_w #(.WIDTH(WIDTH)) u_add (
    .a    (opa_reg),
    .b    (opb_reg),
    .sum  (sum),
    .cout (cout)
  );

  // Acceptance depends on state alone so upstream can never form a loop through in_valid.
  assign in_ready = (state_reg == S_WAIT_A) || (state_reg == S_WAIT_B);

  always_comb begin
    state_next     = state_reg;
    opa_next       = opa_reg;
    opb_next       = opb_reg;
    r_data_next    = r_data_reg;
    carry_next     = carry_reg;
    r_en_next      = 1'b0;
    out_valid_next = out_valid_reg;
    op_count_next  = op_count_reg;
    case (state_reg)
      S_WAIT_A: begin
        if (in_valid) begin
          opa_next   = in_data;
          state_next = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (in_valid) begin
          opb_next   = in_data;
          state_next = S_ADD;
        end
      end
      S_ADD: begin
        r_data_next    = sum;
        carry_next     = cout;
        r_en_next      = 1'b1;
        out_valid_next = 1'b1;
        state_next     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          op_count_next  = op_count_reg + CNT_W'(1);
          state_next     = S_WAIT_A;
        end
      end
      default: state_next = S_WAIT_A;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_WAIT_A;
      opa_reg       <= '0;
      opb_reg       <= '0;
      r_data_reg    <= '0;
      carry_reg     <= 1'b0;
      r_en_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      op_count_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      opa_reg       <= opa_next;
      opb_reg       <= opb_next;
      r_data_reg    <= r_data_next;
      carry_reg     <= carry_next;
      r_en_reg      <= r_en_next;
      out_valid_reg <= out_valid_next;
      op_count_reg  <= op_count_next;
    end
  end

  assign r_data    = r_data_reg;
  assign carry     = carry_reg;
  assign r_en      = r_en_reg;
  assign out_valid = out_valid_reg;
  assign op_count  = op_count_reg;

`ifndef SYNTHESIS
  // Handshake inputs must be known whenever the current state looks at them.
  always @(posedge clk) begin
    if (reset) begin
      if (in_ready) assert (!$isunknown(in_valid));
      if (state_reg == S_DONE) assert (!$isunknown(out_ready));
    end
  end
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl with a bench-side reg8 model.
module tb_adder_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic [7:0] r_data;
  logic       r_en;
  logic       carry;
  logic       out_valid;
  logic [7:0] op_count;

  int passes = 0;
  int total = 0;
  int en_count = 0;
  logic [7:0] reg8_q;

  adder_seq_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .r_data    (r_data),
    .r_en      (r_en),
    .carry     (carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (r_en === 1'b1) en_count++;

  // Downstream reg8: loads r_data on the edge where r_en is high.
  always @(posedge clk or negedge reset) begin
    if (!reset) reg8_q <= 8'h00;
    else if (r_en) reg8_q <= r_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Feeds A and B, then stops in S_DONE with the result visible.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic rdy);
    in_valid = 1'b1;
    in_data  = a;
    chk("in_ready_a", in_ready, 1);
    tick();
    in_data = b;
    chk("in_ready_b", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("in_ready_add", in_ready, 0);
    chk("r_en_add", r_en, 0);
    out_ready = rdy;
    tick();
    chk("r_en_pulse", r_en, 1);
    chk("out_valid_set", out_valid, 1);
  endtask

  function automatic logic [7:0] stim(input int c);
    return 8'((c * 73 + 3) ^ (c >> 4));
  endfunction

  initial begin
    int e0;
    logic [8:0] s;

    // Reset state
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_r_data", r_data, 0);
    chk("rst_carry", carry, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_r_en", r_en, 0);
    chk("rst_out_valid", out_valid, 0);
    reset = 1'b1;
    tick();

    // 1: 25+13
    run_op(8'h25, 8'h13, 1'b1);
    chk("t1_r_data", r_data, 8'h38);
    chk("t1_carry", carry, 0);
    chk("t1_cnt_before", op_count, 0);
    tick();
    chk("t1_r_en_low", r_en, 0);
    chk("t1_out_valid_low", out_valid, 0);
    chk("t1_cnt_after", op_count, 1);
    chk("t1_en_pulses", en_count, 1);
    chk("t1_r_data_held", r_data, 8'h38);
    chk("t1_reg8", reg8_q, 8'h38);

    // 2: FF+01 overflows
    run_op(8'hFF, 8'h01, 1'b1);
    chk("t2_r_data", r_data, 8'h00);
    chk("t2_carry", carry, 1);
    tick();
    chk("t2_reg8", reg8_q, 8'h00);
    chk("t2_cnt", op_count, 2);
    chk("t2_carry_held", carry, 1);

    // 3: consumer stalls for 5 cycles while upstream keeps offering 77
    run_op(8'h40, 8'h41, 1'b0);
    chk("t3_r_data", r_data, 8'h81);
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_r_data", r_data, 8'h81);
      chk("t3_hold_carry", carry, 0);
      chk("t3_hold_in_ready", in_ready, 0);
      chk("t3_hold_r_en", r_en, 0);
      chk("t3_hold_cnt", op_count, 2);
    end
    out_ready = 1'b1;
    tick();
    chk("t3_release_in_ready", in_ready, 1);
    chk("t3_release_valid", out_valid, 0);
    chk("t3_release_cnt", op_count, 3);
    chk("t3_release_r_data", r_data, 8'h81);
    out_ready = 1'b0;
    tick();
    in_data = 8'h01;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t3_stalled_byte_sum", r_data, 8'h78);
    chk("t3_stalled_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("t3_cnt_final", op_count, 4);

    // 4: reset after A is latched discards it
    in_valid = 1'b1;
    in_data  = 8'h10;
    tick();
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("t4_rst_r_data", r_data, 0);
    chk("t4_rst_cnt", op_count, 0);
    chk("t4_rst_in_ready", in_ready, 1);
    chk("t4_rst_valid", out_valid, 0);
    tick();
    reset = 1'b1;
    e0 = en_count;
    tick();
    chk("t4_no_pulse_idle", en_count, e0);
    run_op(8'h01, 8'h02, 1'b1);
    chk("t4_no_pulse_before", en_count, e0);
    chk("t4_r_data", r_data, 8'h03);
    tick();
    chk("t4_cnt", op_count, 1);

    // 5/6: 256 back-to-back operations with in_valid and out_ready tied high
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    e0 = en_count;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = stim(0);
    for (int c = 0; c < 1024; c++) begin
      @(posedge clk);
      @(negedge clk);
      in_data = stim(c + 1);
      chk("t5_r_en_phase", r_en, (c % 4 == 2) ? 1 : 0);
      if (c % 4 == 2) begin
        s = {1'b0, stim(c - 2)} + {1'b0, stim(c - 1)};
        chk("t5_r_data", r_data, s[7:0]);
        chk("t5_carry", carry, s[8]);
        chk("t5_cnt", op_count, (c / 4) % 256);
      end
    end
    in_valid = 1'b0;
    chk("t5_cnt_wrap", op_count, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_pulses", en_count, e0 + 256);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
